// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - control FSM for an N-way set-associative write-back cache
//
// Purpose: steers the per-way tag/data/valid/dirty arrays and the LRU array
// between the CPU request port and the physical-memory port. Misses pick a
// victim (lowest invalid way, else the LRU way), write it back if dirty, then
// fill it; the request then completes through the ordinary hit path.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mem_read/write    CPU request, held until mem_resp (write wins if both)
//   hit/valid/dirty   per-way status of the indexed set
//   lru_way           replacement array's LRU way for the indexed set
//   pmem_resp         physical memory transfer complete pulse
//   mem_resp          CPU request complete
//   pmem_read/write   line fill / line writeback request
//   pmem_addr_sel     0 = request tag/index, 1 = victim tag/index
//   data_in_sel       0 = masked CPU write data, 1 = pmem line
//   way_sel           way driving the read/writeback data mux
//   load_tag .. reset_dirty  one-hot per-way array strobes
//   set_lru, mru_way  replacement state update
//   hit/miss/wb_count saturating performance counters
module cache_control_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_way    = $clog2(num_ways),
  parameter int s_cnt    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [num_ways-1:0] hit,
  input  logic [num_ways-1:0] valid,
  input  logic [num_ways-1:0] dirty,
  input  logic [s_way-1:0]    lru_way,
  input  logic                pmem_resp,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic                pmem_addr_sel,
  output logic                data_in_sel,
  output logic [s_way-1:0]    way_sel,
  output logic [num_ways-1:0] load_tag,
  output logic [num_ways-1:0] load_data,
  output logic [num_ways-1:0] set_valid,
  output logic [num_ways-1:0] set_dirty,
  output logic [num_ways-1:0] reset_dirty,
  output logic                set_lru,
  output logic [s_way-1:0]    mru_way,
  output logic [s_cnt-1:0]    hit_count,
  output logic [s_cnt-1:0]    miss_count,
  output logic [s_cnt-1:0]    wb_count
);

  // Geometry sanity: associativity must be a power of two of at least 2.
  if (num_ways < 2 || (num_ways & (num_ways - 1)) != 0 || s_offset < 0 ||
      s_index < 1 || s_cnt < 1) begin : g_param_check
    $error("cache_control_nway: illegal geometry parameters");
  end

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state, state_next;

  logic [s_way-1:0] victim_q;
  logic [s_way-1:0] victim_sel;
  logic [s_way-1:0] hit_way;
  logic             fill_done;
  logic             request;
  logic             any_hit;
  logic             victim_wb;
  logic             miss_evt;
  logic             wb_evt;

  function automatic logic [num_ways-1:0] way_bit(input logic [s_way-1:0] w);
    way_bit    = '0;
    way_bit[w] = 1'b1;
  endfunction

  function automatic logic [s_cnt-1:0] sat_inc(input logic [s_cnt-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  assign request = mem_read | mem_write;
  assign any_hit = |hit;

  // Lowest-index hit; multiple hits are not expected.
  always_comb begin
    hit_way = '0;
    for (int i = num_ways - 1; i >= 0; i--) begin
      if (hit[i]) hit_way = s_way'(i);
    end
  end

  // Invalid ways are free to fill, so they take precedence over the LRU way.
  always_comb begin
    victim_sel = lru_way;
    for (int i = num_ways - 1; i >= 0; i--) begin
      if (!valid[i]) victim_sel = s_way'(i);
    end
  end

  assign victim_wb = valid[victim_sel] & dirty[victim_sel];
  assign miss_evt  = (state == COMPARE) && request && !any_hit && !rst;
  assign wb_evt    = (state == WRITEBACK) && pmem_resp && !rst;

  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    way_sel       = victim_q;
    load_tag      = '0;
    load_data     = '0;
    set_valid     = '0;
    set_dirty     = '0;
    reset_dirty   = '0;
    set_lru       = 1'b0;
    mru_way       = '0;

    case (state)
      COMPARE: begin
        if (request) begin
          if (any_hit) begin
            mem_resp = 1'b1;
            set_lru  = 1'b1;
            mru_way  = hit_way;
            way_sel  = hit_way;
            if (mem_write) begin
              load_data = way_bit(hit_way);
              set_dirty = way_bit(hit_way);
            end
          end else begin
            state_next = victim_wb ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          reset_dirty = way_bit(victim_q);
          state_next  = FILL;
        end
      end
      FILL: begin
        pmem_read   = 1'b1;
        data_in_sel = 1'b1;
        if (pmem_resp) begin
          load_data   = way_bit(victim_q);
          load_tag    = way_bit(victim_q);
          set_valid   = way_bit(victim_q);
          reset_dirty = way_bit(victim_q);
          state_next  = COMPARE;
        end
      end
      default: state_next = COMPARE;
    endcase

    // Reset is asynchronous, so the combinational outputs are silenced too.
    if (rst) begin
      state_next    = COMPARE;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      data_in_sel   = 1'b0;
      way_sel       = '0;
      load_tag      = '0;
      load_data     = '0;
      set_valid     = '0;
      set_dirty     = '0;
      reset_dirty   = '0;
      set_lru       = 1'b0;
      mru_way       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COMPARE;
      victim_q   <= '0;
      fill_done  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_next;
      if (miss_evt) victim_q <= victim_sel;
      // fill_done marks the post-fill completion so it is not counted as a hit.
      if (mem_resp) fill_done <= 1'b0;
      else if (state == FILL && pmem_resp) fill_done <= 1'b1;
      if (mem_resp && !fill_done) hit_count <= sat_inc(hit_count);
      if (miss_evt) miss_count <= sat_inc(miss_count);
      if (wb_evt) wb_count <= sat_inc(wb_count);
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// tb/tb_cache_control_nway.sv - self-checking bench for cache_control_nway
module tb_cache_control_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, pmem_resp;
  logic [3:0]  hit, valid, dirty;
  logic [1:0]  lru_way;

  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, set_lru;
  logic [1:0]  way_sel, mru_way;
  logic [3:0]  load_tag, load_data, set_valid, set_dirty, reset_dirty;
  logic [31:0] hit_count, miss_count, wb_count;

  logic        mem_resp_4, pmem_read_4, pmem_write_4, pmem_addr_sel_4, data_in_sel_4, set_lru_4;
  logic [1:0]  way_sel_4, mru_way_4;
  logic [3:0]  load_tag_4, load_data_4, set_valid_4, set_dirty_4, reset_dirty_4;
  logic [3:0]  hit_count_4, miss_count_4, wb_count_4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_control_nway dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .valid(valid), .dirty(dirty), .lru_way(lru_way), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel), .way_sel(way_sel),
    .load_tag(load_tag), .load_data(load_data), .set_valid(set_valid),
    .set_dirty(set_dirty), .reset_dirty(reset_dirty), .set_lru(set_lru),
    .mru_way(mru_way), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control_nway #(.s_cnt(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .valid(valid), .dirty(dirty), .lru_way(lru_way), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp_4), .pmem_read(pmem_read_4), .pmem_write(pmem_write_4),
    .pmem_addr_sel(pmem_addr_sel_4), .data_in_sel(data_in_sel_4), .way_sel(way_sel_4),
    .load_tag(load_tag_4), .load_data(load_data_4), .set_valid(set_valid_4),
    .set_dirty(set_dirty_4), .reset_dirty(reset_dirty_4), .set_lru(set_lru_4),
    .mru_way(mru_way_4), .hit_count(hit_count_4), .miss_count(miss_count_4), .wb_count(wb_count_4)
  );

  // Environment arrays, updated from the DUT's strobes.
  logic [3:0] env_valid [8];
  logic [3:0] env_dirty [8];
  logic [7:0] env_tag   [8][4];
  logic [2:0] cur_set;
  logic [7:0] cur_tag;

  always_comb begin
    hit = '0;
    for (int w = 0; w < 4; w++)
      hit[w] = env_valid[cur_set][w] && (env_tag[cur_set][w] == cur_tag);
    valid = env_valid[cur_set];
    dirty = env_dirty[cur_set];
  end

  // Transaction-level reference model.
  bit         ref_valid [8][4];
  bit         ref_dirty [8][4];
  logic [7:0] ref_tag   [8][4];
  int exp_hits, exp_misses, exp_wbs;
  int exp_cycles, exp_vic, exp_way;
  bit exp_miss, exp_wb;

  // Observations from the last transaction.
  int obs_cycles, obs_vic, obs_wb_way, obs_resp_way, obs_mru;
  bit obs_wb, obs_overlap, obs_addr_sel_bad, obs_set_lru, obs_dsel;
  logic [3:0] obs_rd_wb, obs_ld_resp, obs_sd_resp;

  task automatic model_req(input logic [2:0] s, input logic [7:0] t, input bit wr,
                           input logic [1:0] lru, input int nwb, input int nfill);
    bit found = 0;
    exp_way = -1;
    for (int w = 0; w < 4; w++)
      if (exp_way < 0 && ref_valid[s][w] && ref_tag[s][w] == t) exp_way = w;
    exp_miss = (exp_way < 0);
    exp_vic  = int'(lru);
    for (int w = 0; w < 4; w++)
      if (!found && !ref_valid[s][w]) begin exp_vic = w; found = 1; end
    exp_wb = exp_miss && ref_valid[s][exp_vic] && ref_dirty[s][exp_vic];
    exp_cycles = 1 + (exp_wb ? nwb : 0) + (exp_miss ? nfill + 1 : 0);
    if (exp_miss) begin
      exp_misses++;
      if (exp_wb) exp_wbs++;
      ref_tag[s][exp_vic]   = t;
      ref_valid[s][exp_vic] = 1;
      ref_dirty[s][exp_vic] = 0;
      exp_way = exp_vic;
    end else begin
      exp_hits++;
    end
    if (wr) ref_dirty[s][exp_way] = 1;
  endtask

  task automatic apply_strobes(input logic [3:0] lt, input logic [3:0] sv,
                               input logic [3:0] sd, input logic [3:0] rd);
    for (int w = 0; w < 4; w++) begin
      if (lt[w]) env_tag[cur_set][w] = cur_tag;
      if (sv[w]) env_valid[cur_set][w] = 1'b1;
      if (rd[w]) env_dirty[cur_set][w] = 1'b0;
      if (sd[w]) env_dirty[cur_set][w] = 1'b1;
    end
  endtask

  task automatic do_req(input logic [2:0] s, input logic [7:0] t, input bit wr,
                        input logic [1:0] lru, input int nwb, input int nfill);
    int wbc = 0, fc = 0;
    bit done = 0;
    logic [3:0] lt = '0, sv = '0, sd = '0, rd = '0;
    obs_cycles = 0; obs_vic = -1; obs_wb_way = -1; obs_resp_way = -1; obs_mru = -1;
    obs_wb = 0; obs_overlap = 0; obs_addr_sel_bad = 0; obs_set_lru = 0; obs_dsel = 1;
    obs_rd_wb = '0; obs_ld_resp = '0; obs_sd_resp = '0;
    @(negedge clk);
    cur_set = s; cur_tag = t; lru_way = lru;
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(1, 0)) : 1'b1;
    while (!done && obs_cycles < 100) begin
      if (obs_cycles > 0) begin
        @(negedge clk);
        apply_strobes(lt, sv, sd, rd);
      end
      #1;
      pmem_resp = 1'b0;
      if (pmem_write) begin wbc++; pmem_resp = (wbc == nwb); end
      else if (pmem_read) begin fc++; pmem_resp = (fc == nfill); end
      #1;
      obs_cycles++;
      if (pmem_write && pmem_read) obs_overlap = 1;
      if (pmem_write) begin
        obs_wb = 1;
        obs_wb_way = int'(way_sel);
        if (pmem_addr_sel !== 1'b1) obs_addr_sel_bad = 1;
        if (pmem_resp) obs_rd_wb = reset_dirty;
      end
      for (int w = 0; w < 4; w++) if (load_tag[w]) obs_vic = w;
      lt = load_tag; sv = set_valid; sd = set_dirty; rd = reset_dirty;
      if (mem_resp) begin
        done = 1;
        obs_resp_way = int'(way_sel);
        obs_mru      = int'(mru_way);
        obs_set_lru  = set_lru;
        obs_dsel     = data_in_sel;
        obs_ld_resp  = load_data;
        obs_sd_resp  = set_dirty;
      end
    end
    @(negedge clk);
    apply_strobes(lt, sv, sd, rd);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    lru_way = '0; cur_set = '0; cur_tag = '0;
    for (int s = 0; s < 8; s++) begin
      env_valid[s] = '0; env_dirty[s] = '0;
      for (int w = 0; w < 4; w++) begin
        env_tag[s][w] = '0; ref_tag[s][w] = '0; ref_valid[s][w] = 0; ref_dirty[s][w] = 0;
      end
    end
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({hit_count, miss_count, wb_count} !== '0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", hit_count, miss_count, wb_count);
    end
    rst = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total++;
    if ({mem_resp, pmem_read, pmem_write, way_sel, load_tag, set_valid} !== '0) begin
      bad++; $display("FAIL idle_after_stray_resp got rd=%b wr=%b resp=%b want 0", pmem_read, pmem_write, mem_resp);
    end
  endtask

  task automatic test_cold_read;
    model_req(3'd0, 8'h11, 0, 2'd3, 0, 3);
    do_req(3'd0, 8'h11, 0, 2'd3, 0, 3);
    total++;
    if (obs_vic !== 0 || obs_wb !== 0) begin
      bad++; $display("FAIL cold_victim got vic=%0d wb=%0d want vic=0 wb=0", obs_vic, obs_wb);
    end
    total++;
    if (obs_cycles !== 5) begin
      bad++; $display("FAIL cold_latency got=%0d want=5", obs_cycles);
    end
    total++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      bad++; $display("FAIL cold_counters got miss=%0d hit=%0d want miss=1 hit=0", miss_count, hit_count);
    end
    total++;
    if (env_valid[0] !== 4'b0001 || env_tag[0][0] !== 8'h11) begin
      bad++; $display("FAIL cold_fill_strobes got valid=%b tag=%h want valid=0001 tag=11", env_valid[0], env_tag[0][0]);
    end
  endtask

  task automatic test_read_hit;
    model_req(3'd0, 8'h11, 0, 2'd1, 0, 1);
    do_req(3'd0, 8'h11, 0, 2'd1, 0, 1);
    total++;
    if (obs_cycles !== 1 || obs_set_lru !== 1 || obs_mru !== 0 || obs_resp_way !== 0) begin
      bad++; $display("FAIL read_hit got cyc=%0d lru=%0d mru=%0d way=%0d want 1/1/0/0",
                      obs_cycles, obs_set_lru, obs_mru, obs_resp_way);
    end
    total++;
    if (hit_count !== 32'd1) begin
      bad++; $display("FAIL read_hit_count got=%0d want=1", hit_count);
    end
  endtask

  task automatic test_dirty_write_miss;
    env_valid[1] = 4'b1111; env_dirty[1] = 4'b0100;
    for (int w = 0; w < 4; w++) begin
      env_tag[1][w] = 8'h20 + 8'(w); ref_tag[1][w] = 8'h20 + 8'(w);
      ref_valid[1][w] = 1; ref_dirty[1][w] = (w == 2);
    end
    model_req(3'd1, 8'h30, 1, 2'd2, 2, 2);
    do_req(3'd1, 8'h30, 1, 2'd2, 2, 2);
    total++;
    if (obs_wb !== 1 || obs_wb_way !== 2 || obs_addr_sel_bad !== 0 || obs_rd_wb !== 4'b0100) begin
      bad++; $display("FAIL dirty_wb got wb=%0d way=%0d addr_bad=%0d rd=%b want 1/2/0/0100",
                      obs_wb, obs_wb_way, obs_addr_sel_bad, obs_rd_wb);
    end
    total++;
    if (obs_ld_resp !== 4'b0100 || obs_sd_resp !== 4'b0100 || obs_dsel !== 0) begin
      bad++; $display("FAIL write_merge got ld=%b sd=%b dsel=%0d want 0100/0100/0", obs_ld_resp, obs_sd_resp, obs_dsel);
    end
    total++;
    if (wb_count !== 32'd1 || obs_cycles !== 6 || env_dirty[1] !== 4'b0100 || env_tag[1][2] !== 8'h30) begin
      bad++; $display("FAIL dirty_miss_result got wb=%0d cyc=%0d dirty=%b tag=%h want 1/6/0100/30",
                      wb_count, obs_cycles, env_dirty[1], env_tag[1][2]);
    end
  endtask

  task automatic test_victim_invalid;
    env_valid[2] = 4'b1011; env_dirty[2] = 4'b1111;
    for (int w = 0; w < 4; w++) begin
      env_tag[2][w] = 8'h50; ref_tag[2][w] = 8'h50;
      ref_valid[2][w] = (w != 2); ref_dirty[2][w] = 1;
    end
    model_req(3'd2, 8'h40, 0, 2'd0, 1, 1);
    do_req(3'd2, 8'h40, 0, 2'd0, 1, 1);
    total++;
    if (obs_vic !== 2 || obs_wb !== 0 || obs_cycles !== 3) begin
      bad++; $display("FAIL invalid_victim got vic=%0d wb=%0d cyc=%0d want 2/0/3", obs_vic, obs_wb, obs_cycles);
    end
  endtask

  task automatic test_reset_mid_fill;
    int waited = 0;
    @(negedge clk);
    cur_set = 3'd3; cur_tag = 8'h77; lru_way = 2'd1; mem_read = 1'b1;
    while (!(pmem_read === 1'b1) && waited < 10) begin @(negedge clk); waited++; end
    @(negedge clk);
    total++;
    if (pmem_read !== 1'b1) begin
      bad++; $display("FAIL reach_fill got pmem_read=%b want 1", pmem_read);
    end
    #1;
    // A hitting request is presented while reset is held; outputs must stay quiet.
    rst = 1'b1; cur_set = 3'd0; cur_tag = 8'h11;
    #1;
    total++;
    if ({mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, way_sel, load_tag,
         load_data, set_valid, set_dirty, reset_dirty, set_lru, mru_way} !== '0) begin
      bad++; $display("FAIL reset_outputs got resp=%b rd=%b lru=%b want all 0", mem_resp, pmem_read, set_lru);
    end
    total++;
    if ({hit_count, miss_count, wb_count, hit_count_4, miss_count_4, wb_count_4} !== '0) begin
      bad++; $display("FAIL reset_mid_fill_counters got=%0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
    end
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    model_req(3'd3, 8'h77, 0, 2'd1, 0, 2);
    do_req(3'd3, 8'h77, 0, 2'd1, 0, 2);
    total++;
    if (obs_cycles !== exp_cycles || obs_vic !== 0 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
      bad++; $display("FAIL remiss_after_reset got cyc=%0d vic=%0d miss=%0d hit=%0d want %0d/0/1/0",
                      obs_cycles, obs_vic, miss_count, hit_count, exp_cycles);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] s = 3'(4 + $urandom_range(3, 0));
      logic [7:0] t = 8'(8'h80 + $urandom_range(5, 0));
      bit wr = 1'($urandom_range(1, 0));
      logic [1:0] lru = 2'($urandom_range(3, 0));
      int nwb = $urandom_range(3, 1);
      int nfill = $urandom_range(3, 1);
      bit arrays_ok = 1;
      model_req(s, t, wr, lru, nwb, nfill);
      do_req(s, t, wr, lru, nwb, nfill);
      for (int w = 0; w < 4; w++)
        if (env_valid[s][w] !== ref_valid[s][w] || env_dirty[s][w] !== ref_dirty[s][w] ||
            (ref_valid[s][w] && env_tag[s][w] !== ref_tag[s][w])) arrays_ok = 0;
      total++;
      if (obs_cycles !== exp_cycles || obs_wb !== exp_wb || obs_overlap !== 0 ||
          (exp_miss && obs_vic !== exp_vic) || obs_resp_way !== exp_way || !arrays_ok) begin
        bad++; $display("FAIL rand_txn[%0d] got cyc=%0d wb=%0d vic=%0d way=%0d arr=%0d want %0d/%0d/%0d/%0d/1",
                        i, obs_cycles, obs_wb, obs_vic, obs_resp_way, arrays_ok,
                        exp_cycles, exp_wb, exp_vic, exp_way);
      end
      total++;
      if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses) || wb_count !== 32'(exp_wbs)) begin
        bad++; $display("FAIL rand_counters[%0d] got %0d/%0d/%0d want %0d/%0d/%0d",
                        i, hit_count, miss_count, wb_count, exp_hits, exp_misses, exp_wbs);
      end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      model_req(3'd0, 8'h11, 1'($urandom_range(1, 0)), 2'd0, 1, 1);
      do_req(3'd0, 8'h11, 0, 2'd0, 1, 1);
    end
    total++;
    if (hit_count_4 !== 4'(exp_hits > 15 ? 15 : exp_hits)) begin
      bad++; $display("FAIL sat_hit4 got=%0d want=%0d", hit_count_4, (exp_hits > 15 ? 15 : exp_hits));
    end
    total++;
    if (hit_count !== 32'(exp_hits) || miss_count_4 !== 4'(exp_misses > 15 ? 15 : exp_misses)) begin
      bad++; $display("FAIL sat_wide got hit=%0d miss4=%0d want %0d/%0d", hit_count, miss_count_4,
                      exp_hits, (exp_misses > 15 ? 15 : exp_misses));
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_dirty_write_miss();
    test_victim_invalid();
    test_reset_mid_fill();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
